// File: rtl/line_buf_reader.sv
// rtl/line_buf_reader.sv - read-side sequencer streaming one buffered line over a valid/ready port
// Optional feature macro: LBR_PIX_DOUBLE_EN (emit every pixel twice for horizontal x2 scaling)

module line_buf_reader #(
   parameter int WIDTH  = 1,
   parameter int DEPTH  = 800,
   parameter int DEPBIT = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DEPBIT-1:0] line_len,
   output logic              busy,
   output logic [DEPBIT-1:0] raddr,
   input  logic [WIDTH-1:0]  rdata,
   output logic [WIDTH-1:0]  pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [DEPBIT-1:0] len_q, len_d;
   logic [DEPBIT-1:0] cnt_q, cnt_d;
   logic [DEPBIT-1:0] raddr_d;
   logic [WIDTH-1:0]  data_d;
   logic              valid_d, last_d, busy_d, done_d;
   logic              load;
   logic              at_last_idx;
   logic [DEPBIT-1:0] len_clip;
`ifdef LBR_PIX_DOUBLE_EN
   logic              phase_q, phase_d;
`endif

   // State and output register; every output is registered so the reset clears them at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         raddr     <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef LBR_PIX_DOUBLE_EN
         phase_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         raddr     <= raddr_d;
         pix_data  <= data_d;
         pix_valid <= valid_d;
         pix_last  <= last_d;
         busy      <= busy_d;
         done      <= done_d;
`ifdef LBR_PIX_DOUBLE_EN
         phase_q   <= phase_d;
`endif
      end
   end

   // Next-state and datapath: the output stage reloads whenever it is empty or being drained
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      raddr_d     = raddr;
      data_d      = pix_data;
      valid_d     = pix_valid;
      last_d      = pix_last;
      busy_d      = busy;
      done_d      = 1'b0;
`ifdef LBR_PIX_DOUBLE_EN
      phase_d     = phase_q;
`endif
      load        = !pix_valid || pix_ready;
      at_last_idx = (cnt_q == len_q - DEPBIT'(1));
      len_clip    = (line_len > DEPBIT'(DEPTH)) ? DEPBIT'(DEPTH) : line_len;

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d = len_clip;
               if (len_clip == '0) begin
                  // Empty line: acknowledge with done but never raise busy or valid
                  done_d = 1'b1;
               end else begin
                  raddr_d = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
`ifdef LBR_PIX_DOUBLE_EN
                  phase_d = 1'b0;
`endif
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (load) begin
               data_d  = rdata;
               valid_d = 1'b1;
`ifdef LBR_PIX_DOUBLE_EN
               // Address only advances after the second copy of a pixel
               phase_d = !phase_q;
               last_d  = at_last_idx && phase_q;
               if (phase_q) begin
                  if (at_last_idx) begin
                     state_d = DRAIN;
                  end else begin
                     cnt_d   = cnt_q + DEPBIT'(1);
                     raddr_d = cnt_q + DEPBIT'(1);
                  end
               end
`else
               last_d = at_last_idx;
               if (at_last_idx) begin
                  state_d = DRAIN;
               end else begin
                  cnt_d   = cnt_q + DEPBIT'(1);
                  raddr_d = cnt_q + DEPBIT'(1);
               end
`endif
            end
         end
         DRAIN: begin
            if (pix_valid && pix_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_buf_reader.sv
// tb/tb_line_buf_reader.sv - directed self-checking bench for line_buf_reader
module tb_line_buf_reader;

   localparam int WIDTH  = 1;
   localparam int DEPTH  = 800;
   localparam int DEPBIT = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DEPBIT-1:0] line_len;
   logic              busy;
   logic [DEPBIT-1:0] raddr;
   logic [WIDTH-1:0]  rdata;
   logic [WIDTH-1:0]  pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;
   logic              done;

   logic [WIDTH-1:0]  mem [DEPTH];
   bit                pat [7];
   int                plen;
   int                nvec = 0;
   int                nerr = 0;

`ifdef LBR_PIX_DOUBLE_EN
   localparam int COPIES = 2;
`else
   localparam int COPIES = 1;
`endif

   line_buf_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPBIT(DEPBIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .line_len  (line_len),
      .busy      (busy),
      .raddr     (raddr),
      .rdata     (rdata),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_last  (pix_last),
      .done      (done)
   );

   // Asynchronous-read buffer model
   assign rdata = mem[raddr];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a line, then collects accepted beats following the ready pattern until done
   task automatic run_line(input int len, input int exp_pix, input int restart_at, input string tag);
      int nb, ndone, cyc, idx, ea, exp_beats;
      bit stall, restarted;
      logic [WIDTH-1:0] pd;
      logic pl;
      logic [DEPBIT-1:0] pa;
      exp_beats = exp_pix * COPIES;
      nb = 0; ndone = 0; cyc = 0; stall = 0; restarted = 0;
      pd = '0; pl = 1'b0; pa = '0;
      @(negedge clk);
      start = 1'b1;
      line_len = DEPBIT'(len);
      pix_ready = pat[0];
      while (ndone == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (stall) begin
            chk({tag, " stall valid"}, 32'(pix_valid), 32'd1);
            chk({tag, " stall data"},  32'(pix_data),  32'(pd));
            chk({tag, " stall last"},  32'(pix_last),  32'(pl));
            chk({tag, " stall raddr"}, 32'(raddr),     32'(pa));
         end
         if (done) ndone++;
         pix_ready = pat[cyc % plen];
         if (restart_at >= 0 && nb == restart_at && !restarted) begin
            start = 1'b1;
            line_len = DEPBIT'(2);
            restarted = 1;
         end
         if (pix_valid && pix_ready) begin
            idx = nb / COPIES;
            if (COPIES == 2 && (nb % 2) == 0) ea = idx;
            else ea = (idx + 1 < exp_pix) ? idx + 1 : exp_pix - 1;
            chk({tag, " data"},  32'(pix_data), 32'(mem[idx]));
            chk({tag, " last"},  32'(pix_last), 32'(nb == exp_beats - 1));
            chk({tag, " raddr"}, 32'(raddr),    32'(ea));
            nb++;
         end
         stall = pix_valid && !pix_ready;
         pd = pix_data; pl = pix_last; pa = raddr;
      end
      chk({tag, " beats"}, 32'(nb), 32'(exp_beats));
      chk({tag, " dones"}, 32'(ndone), 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk({tag, " post done"},  32'(done),      32'd0);
      chk({tag, " post busy"},  32'(busy),      32'd0);
      chk({tag, " post valid"}, 32'(pix_valid), 32'd0);
   endtask

   initial begin
      int cnt;
      logic e1 [4];
      rst = 1'b1; start = 1'b0; pix_ready = 1'b0; line_len = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(0, 1));
      mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1; mem[4] = 1'b0; mem[5] = 1'b1;
      e1[0] = 1'b1; e1[1] = 1'b0; e1[2] = 1'b1; e1[3] = 1'b1;
      for (int i = 0; i < 7; i++) pat[i] = 1'b1;
      plen = 1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst busy",  32'(busy),      32'd0);
      chk("rst raddr", 32'(raddr),     32'd0);
      chk("rst data",  32'(pix_data),  32'd0);
      chk("rst valid", 32'(pix_valid), 32'd0);
      chk("rst last",  32'(pix_last),  32'd0);
      chk("rst done",  32'(done),      32'd0);
      rst = 1'b0;

`ifndef LBR_PIX_DOUBLE_EN
      // Four-pixel line with ready held high, checked cycle by cycle
      @(negedge clk);
      start = 1'b1; line_len = DEPBIT'(4); pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t1 c0 busy",  32'(busy),      32'd1);
      chk("t1 c0 valid", 32'(pix_valid), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t1 valid", 32'(pix_valid), 32'd1);
         chk("t1 data",  32'(pix_data),  32'(e1[i-1]));
         chk("t1 last",  32'(pix_last),  32'(i == 4));
         chk("t1 raddr", 32'(raddr),     32'((i < 4) ? i : 3));
         chk("t1 done",  32'(done),      32'd0);
         chk("t1 busy",  32'(busy),      32'd1);
      end
      @(negedge clk);
      chk("t1 c5 valid", 32'(pix_valid), 32'd0);
      chk("t1 c5 done",  32'(done),      32'd1);
      chk("t1 c5 busy",  32'(busy),      32'd0);
      @(negedge clk);
      chk("t1 c6 done",  32'(done),      32'd0);
`else
      // Doubled line: 1,0,1 -> 1,1,0,0,1,1 with last on the sixth beat
      run_line(3, 3, -1, "dbl");
`endif

      // Same line under back-pressure
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
      plen = 7;
      run_line(4, 4, -1, "t2");

      // Empty line
      plen = 1; pat[0] = 1'b1;
      @(negedge clk);
      start = 1'b1; line_len = '0; pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t3 done",  32'(done),      32'd1);
      chk("t3 busy",  32'(busy),      32'd0);
      chk("t3 valid", 32'(pix_valid), 32'd0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cnt += int'(done) + int'(busy) + int'(pix_valid);
      end
      chk("t3 quiet", 32'(cnt), 32'd0);

      // Oversized request clipped to DEPTH
      run_line(1000, DEPTH, -1, "t4");

      // Start during a line is ignored; a later start works
      run_line(4, 4, 2, "t5a");
      run_line(4, 4, -1, "t5b");

      // Reset in mid-line
      @(negedge clk);
      start = 1'b1; line_len = DEPBIT'(6); pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6 pre valid", 32'(pix_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6 busy",  32'(busy),      32'd0);
      chk("t6 raddr", 32'(raddr),     32'd0);
      chk("t6 data",  32'(pix_data),  32'd0);
      chk("t6 valid", 32'(pix_valid), 32'd0);
      chk("t6 last",  32'(pix_last),  32'd0);
      chk("t6 done",  32'(done),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cnt += int'(done) + int'(busy);
      end
      chk("t6 no done", 32'(cnt), 32'd0);
      run_line(3, 3, -1, "t6b");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
